// File: rtl/pipeline_stage_elastic.sv
// Elastic inter-stage pipeline register: a DEPTH-entry circular buffer with
// a valid/ready handshake, a synchronous flush and a saturating stall counter.
module pipeline_stage_elastic #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 2,
    parameter int CNT_W    = 16,
    parameter int CLR_DATA = 1
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       flush_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [WIDTH-1:0]           in_data_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [WIDTH-1:0]           out_data_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic [CNT_W-1:0]           stall_cnt_o
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [CNT_W-1:0] stall_q, stall_d;

    logic full, empty, push, pop, stall;

    // Wrap explicitly so that DEPTH need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    // in_ready comes only from registered occupancy, never from out_ready.
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign push  = in_valid_i && !full;
    assign pop   = !empty && out_ready_i;
    assign stall = in_valid_i && full;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        stall_d  = stall_q;

        if (stall && (stall_q != '1)) begin
            stall_d = stall_q + 1'b1;
        end

        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            stall_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            stall_q  <= stall_d;
        end
    end

    // A flush drops the incoming word; with CLR_DATA it also scrubs storage.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            if (CLR_DATA != 0) begin
                for (int i = 0; i < DEPTH; i++) begin
                    mem_q[i] <= '0;
                end
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= in_data_i;
        end
    end

    assign in_ready_o  = !full;
    assign out_valid_o = !empty;
    assign out_data_o  = mem_q[rd_ptr_q];
    assign count_o     = count_q;
    assign stall_cnt_o = stall_q;

endmodule

// File: tb/tb_pipeline_stage_elastic.sv
// Bench for pipeline_stage_elastic: three instances (DEPTH 2, DEPTH 3, CNT_W 4)
// checked every cycle against a list-based model plus hand-computed literals.
module tb_pipeline_stage_elastic;

    logic clk_i = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk_i = ~clk_i;

    logic        iv   [3];
    logic        ordy [3];
    logic        fl   [3];
    logic [31:0] id   [3];
    logic        ov   [3];
    logic        ir   [3];
    logic [31:0] od   [3];
    logic [1:0]  cnt  [3];
    logic [15:0] st   [3];
    logic [15:0] st0, st1;
    logic [3:0]  st2;

    assign st[0] = st0;
    assign st[1] = st1;
    assign st[2] = {12'b0, st2};

    pipeline_stage_elastic #(.WIDTH(32), .DEPTH(2), .CNT_W(16), .CLR_DATA(1)) u_d2 (
        .clk_i(clk_i), .rst_n_i(rst_n), .flush_i(fl[0]), .in_valid_i(iv[0]),
        .in_ready_o(ir[0]), .in_data_i(id[0]), .out_valid_o(ov[0]),
        .out_ready_i(ordy[0]), .out_data_o(od[0]), .count_o(cnt[0]), .stall_cnt_o(st0));

    pipeline_stage_elastic #(.WIDTH(32), .DEPTH(3), .CNT_W(16), .CLR_DATA(1)) u_d3 (
        .clk_i(clk_i), .rst_n_i(rst_n), .flush_i(fl[1]), .in_valid_i(iv[1]),
        .in_ready_o(ir[1]), .in_data_i(id[1]), .out_valid_o(ov[1]),
        .out_ready_i(ordy[1]), .out_data_o(od[1]), .count_o(cnt[1]), .stall_cnt_o(st1));

    pipeline_stage_elastic #(.WIDTH(32), .DEPTH(2), .CNT_W(4), .CLR_DATA(1)) u_sat (
        .clk_i(clk_i), .rst_n_i(rst_n), .flush_i(fl[2]), .in_valid_i(iv[2]),
        .in_ready_o(ir[2]), .in_data_i(id[2]), .out_valid_o(ov[2]),
        .out_ready_i(ordy[2]), .out_data_o(od[2]), .count_o(cnt[2]), .stall_cnt_o(st2));

    // Model: e[0] is the head of an ordered list of n entries.
    typedef struct packed {
        logic [31:0]       n;
        logic [31:0]       stall;
        logic [3:0][31:0]  e;
    } model_t;

    model_t      mdl [3];
    logic [31:0] got1 [$];
    int          n_pass  = 0;
    int          n_total = 0;

    function automatic int cap_of(input int k);
        return (k == 1) ? 3 : 2;
    endfunction

    function automatic int smax_of(input int k);
        return (k == 2) ? 15 : 65535;
    endfunction

    function automatic model_t step(input model_t m, input int cap, input int smax,
                                    input logic v, input logic [31:0] d,
                                    input logic r, input logic f);
        model_t o;
        bit     is_full, do_push, do_pop;
        o       = m;
        is_full = (int'(m.n) == cap);
        do_push = v && !is_full;
        do_pop  = (m.n != 0) && r;
        if (v && is_full && int'(m.stall) < smax) o.stall = m.stall + 1;
        if (f) begin
            o.n = 0;
            return o;
        end
        if (do_pop) begin
            for (int i = 0; i < 3; i++) o.e[i] = o.e[i+1];
            o.n = o.n - 1;
        end
        if (do_push) begin
            o.e[o.n] = d;
            o.n = o.n + 1;
        end
        return o;
    endfunction

    task automatic chk(input string nm, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s inst%0d @%0t: got %0h expected %0h", nm, k, $time, act, exp);
    endtask

    always @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) mdl[k] <= '0;
        end else begin
            for (int k = 0; k < 3; k++)
                mdl[k] <= step(mdl[k], cap_of(k), smax_of(k), iv[k], id[k], ordy[k], fl[k]);
        end
    end

    always @(negedge clk_i) begin
        if (rst_n) begin
            for (int k = 0; k < 3; k++) begin
                chk("out_valid", k, 32'(ov[k]), 32'(mdl[k].n != 0));
                chk("in_ready", k, 32'(ir[k]), 32'(int'(mdl[k].n) != cap_of(k)));
                chk("count", k, 32'(cnt[k]), mdl[k].n);
                chk("count_le_cap", k, 32'(int'(cnt[k]) <= cap_of(k)), 32'd1);
                chk("stall_cnt", k, 32'(st[k]), mdl[k].stall);
                if (mdl[k].n != 0) chk("out_data", k, od[k], mdl[k].e[0]);
            end
            if (ov[1] && ordy[1]) got1.push_back(od[1]);
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        int guard;
        bit acc;
        for (int k = 0; k < 3; k++) begin
            iv[k] = 1'b0; ordy[k] = 1'b0; fl[k] = 1'b0; id[k] = '0;
        end

        // T1 reset held
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_out_valid", 0, 32'(ov[0]), 32'd0);
        chk("rst_in_ready", 0, 32'(ir[0]), 32'd1);
        chk("rst_count", 0, 32'(cnt[0]), 32'd0);
        chk("rst_out_data", 0, od[0], 32'd0);
        chk("rst_stall", 0, 32'(st[0]), 32'd0);
        chk("rst_stall", 2, 32'(st[2]), 32'd0);
        @(negedge clk_i);
        rst_n = 1'b1;
        tick();

        // T2 streaming
        ordy[0] = 1'b1; iv[0] = 1'b1; id[0] = 32'hA;
        tick();
        chk("t2_data_a", 0, od[0], 32'hA);
        chk("t2_count", 0, 32'(cnt[0]), 32'd1);
        id[0] = 32'hB;
        tick();
        chk("t2_data_b", 0, od[0], 32'hB);
        chk("t2_count", 0, 32'(cnt[0]), 32'd1);
        id[0] = 32'hC;
        tick();
        chk("t2_data_c", 0, od[0], 32'hC);
        chk("t2_valid", 0, 32'(ov[0]), 32'd1);
        iv[0] = 1'b0;
        tick();
        chk("t2_empty", 0, 32'(cnt[0]), 32'd0);

        // T3 backpressure
        ordy[0] = 1'b0; iv[0] = 1'b1; id[0] = 32'h11;
        tick();
        id[0] = 32'h22;
        tick();
        chk("t3_full_count", 0, 32'(cnt[0]), 32'd2);
        chk("t3_in_ready", 0, 32'(ir[0]), 32'd0);
        id[0] = 32'h33;
        repeat (3) tick();
        chk("t3_stall3", 0, 32'(st[0]), 32'd3);
        chk("t3_head", 0, od[0], 32'h11);
        ordy[0] = 1'b1;
        tick();
        chk("t3_pop2", 0, od[0], 32'h22);
        chk("t3_stall4", 0, 32'(st[0]), 32'd4);
        tick();
        chk("t3_pop3", 0, od[0], 32'h33);
        chk("t3_count", 0, 32'(cnt[0]), 32'd1);
        iv[0] = 1'b0;
        tick();
        chk("t3_drained", 0, 32'(ov[0]), 32'd0);

        // T4 flush while full, incoming word dropped
        ordy[0] = 1'b0; iv[0] = 1'b1; id[0] = 32'h55;
        tick();
        id[0] = 32'h66;
        tick();
        id[0] = 32'h44; fl[0] = 1'b1;
        tick();
        fl[0] = 1'b0; iv[0] = 1'b0;
        chk("t4_count", 0, 32'(cnt[0]), 32'd0);
        chk("t4_valid", 0, 32'(ov[0]), 32'd0);
        chk("t4_in_ready", 0, 32'(ir[0]), 32'd1);
        chk("t4_data_zero", 0, od[0], 32'd0);
        chk("t4_stall_kept", 0, 32'(st[0]), 32'd5);
        tick();
        chk("t4_no_0x44", 0, 32'(ov[0]), 32'd0);

        // T5 wrap with DEPTH 3 and random out_ready
        for (int i = 0; i < 10; i++) begin
            iv[1] = 1'b1; id[1] = 32'h100 + 32'(i);
            acc = 1'b0; guard = 0;
            while (!acc && guard < 20) begin
                ordy[1] = 1'($urandom_range(0, 1));
                acc = ir[1];
                tick();
                guard++;
            end
            if (!acc) chk("t5_push_timeout", 1, 32'd0, 32'd1);
        end
        iv[1] = 1'b0; ordy[1] = 1'b1; guard = 0;
        while (ov[1] && guard < 20) begin
            tick();
            guard++;
        end
        chk("t5_drained", 1, 32'(ov[1]), 32'd0);
        ordy[1] = 1'b0;
        chk("t5_pop_count", 1, 32'(got1.size()), 32'd10);
        for (int i = 0; i < 10 && i < got1.size(); i++)
            chk("t5_order", 1, got1[i], 32'h100 + 32'(i));

        // stall counter saturation at CNT_W=4
        iv[2] = 1'b1; id[2] = 32'h5A;
        repeat (22) tick();
        chk("sat_stall15", 2, 32'(st[2]), 32'd15);
        chk("sat_count", 2, 32'(cnt[2]), 32'd2);
        iv[2] = 1'b0;

        // T6 async reset mid-clock with two entries held
        ordy[0] = 1'b0; iv[0] = 1'b1; id[0] = 32'h77;
        tick();
        id[0] = 32'h88;
        tick();
        iv[0] = 1'b0;
        chk("t6_pre_count", 0, 32'(cnt[0]), 32'd2);
        @(posedge clk_i);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_count", 0, 32'(cnt[0]), 32'd0);
        chk("t6_valid", 0, 32'(ov[0]), 32'd0);
        chk("t6_in_ready", 0, 32'(ir[0]), 32'd1);
        chk("t6_data", 0, od[0], 32'd0);
        chk("t6_stall", 0, 32'(st[0]), 32'd0);
        chk("t6_stall_sat", 2, 32'(st[2]), 32'd0);
        @(negedge clk_i);
        #1;
        rst_n = 1'b1;
        tick();
        chk("t6_after", 0, 32'(ov[0]), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
